// File: rtl/cpu_mem_seq.sv
// Host-side sequencer that loads I-mem/D-mem, starts a CPU run and
// reports halt/timeout status back to the host.
`timescale 1ns/1ps
module cpu_mem_seq #(
    parameter int AW  = 8,
    parameter int DW  = 16,
    parameter int TMO = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          h_valid,
    output logic          h_ready,
    input  logic [1:0]    h_cmd,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          r_valid,
    output logic [DW-1:0] r_data,
    output logic [1:0]    r_status,
    output logic          cpu_enable,
    output logic          cpu_start,
    input  logic          cpu_halt,
    input  logic [AW-1:0] cpu_i_addr,
    input  logic [AW-1:0] cpu_d_addr,
    input  logic          cpu_d_we,
    input  logic [DW-1:0] cpu_d_wdata,
    output logic [AW-1:0] im_addr,
    output logic          im_we,
    output logic [DW-1:0] im_wdata,
    output logic [AW-1:0] dm_addr,
    output logic          dm_we,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata
);

    localparam int CW = $clog2(TMO) + 1;

    localparam logic [1:0] CMD_WRI = 2'b00;
    localparam logic [1:0] CMD_WRD = 2'b01;
    localparam logic [1:0] CMD_RDD = 2'b10;
    localparam logic [1:0] CMD_RUN = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_HALTED  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_DATA,
        START,
        RUN,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    status_nx;
    logic          rdy_q;
    logic [1:0]    cmd_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          in_run;

    assign accept  = h_valid && h_ready;
    assign in_run  = (state == RUN);
    assign h_ready = (state == IDLE) && rdy_q;

    // Next-state and response-status selection
    always_comb begin
        state_nx  = state;
        status_nx = ST_OK;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (h_cmd)
                        CMD_WRI: state_nx = WRITE;
                        CMD_WRD: state_nx = WRITE;
                        CMD_RDD: state_nx = RD_ADDR;
                        CMD_RUN: state_nx = START;
                    endcase
                end
            end
            WRITE:   state_nx = RESP;
            RD_ADDR: state_nx = RD_DATA;
            RD_DATA: state_nx = RESP;
            START:   state_nx = RUN;
            RUN: begin
                // halt takes priority when it lands on the last allowed cycle
                if (cpu_halt) begin
                    state_nx  = RESP;
                    status_nx = ST_HALTED;
                end else if (cnt == CNT_LAST) begin
                    state_nx  = RESP;
                    status_nx = ST_TIMEOUT;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register; rdy_q keeps h_ready low until a cycle after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nx;
            rdy_q <= 1'b1;
        end
    end

    // Latch the host command on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q   <= CMD_WRI;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            cmd_q   <= h_cmd;
            addr_q  <= h_addr;
            wdata_q <= h_wdata;
        end
    end

    // Response registers hold until the next response overwrites them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_status <= ST_OK;
        end else begin
            if (state == RD_DATA) begin
                r_data <= dm_rdata;
            end
            if (state_nx == RESP) begin
                r_status <= status_nx;
            end
        end
    end

    // CPU enable spans START and RUN, dropping on the edge into RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_enable <= 1'b0;
        end else begin
            cpu_enable <= (state_nx == START) || (state_nx == RUN);
        end
    end

    // Run-cycle counter: cleared on RUN entry, saturating while running
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == START) begin
            cnt <= '0;
        end else if (in_run && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign r_valid   = (state == RESP);
    assign cpu_start = (state == START);

    // Memory port mux: CPU owns the ports only while running
    always_comb begin
        im_addr  = addr_q;
        im_wdata = wdata_q;
        im_we    = 1'b0;
        dm_addr  = addr_q;
        dm_wdata = wdata_q;
        dm_we    = 1'b0;
        if (in_run) begin
            im_addr  = cpu_i_addr;
            dm_addr  = cpu_d_addr;
            dm_wdata = cpu_d_wdata;
            dm_we    = cpu_d_we && !rst;
        end else if (state == WRITE) begin
            im_we = (cmd_q == CMD_WRI) && !rst;
            dm_we = (cmd_q == CMD_WRD) && !rst;
        end
    end

endmodule

// File: tb/tb_cpu_mem_seq.sv
// Scoreboard bench for cpu_mem_seq with behavioural memories, a tiny
// accumulator CPU stub and an ISA-level reference model.
`timescale 1ns/1ps
module tb_cpu_mem_seq;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TMO = 64;

    localparam logic [1:0] C_WRI = 2'b00;
    localparam logic [1:0] C_WRD = 2'b01;
    localparam logic [1:0] C_RDD = 2'b10;
    localparam logic [1:0] C_RUN = 2'b11;

    localparam logic [1:0] S_OK  = 2'b00;
    localparam logic [1:0] S_HLT = 2'b01;
    localparam logic [1:0] S_TMO = 2'b10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          h_valid = 1'b0;
    logic          h_ready;
    logic [1:0]    h_cmd = 2'b00;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_wdata = '0;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [1:0]    r_status;
    logic          cpu_enable;
    logic          cpu_start;
    logic          cpu_halt;
    logic [AW-1:0] cpu_i_addr;
    logic [AW-1:0] cpu_d_addr;
    logic          cpu_d_we;
    logic [DW-1:0] cpu_d_wdata;
    logic [AW-1:0] im_addr;
    logic          im_we;
    logic [DW-1:0] im_wdata;
    logic [AW-1:0] dm_addr;
    logic          dm_we;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata = '0;

    cpu_mem_seq #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .h_valid(h_valid), .h_ready(h_ready), .h_cmd(h_cmd),
        .h_addr(h_addr), .h_wdata(h_wdata),
        .r_valid(r_valid), .r_data(r_data), .r_status(r_status),
        .cpu_enable(cpu_enable), .cpu_start(cpu_start),
        .cpu_halt(cpu_halt), .cpu_i_addr(cpu_i_addr),
        .cpu_d_addr(cpu_d_addr), .cpu_d_we(cpu_d_we),
        .cpu_d_wdata(cpu_d_wdata),
        .im_addr(im_addr), .im_we(im_we), .im_wdata(im_wdata),
        .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    // Physical memories driven by the DUT
    logic [DW-1:0] imem [256];
    logic [DW-1:0] dmem [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i] = '0;
            dmem[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (im_we) imem[im_addr] <= im_wdata;
        if (dm_we) dmem[dm_addr] <= dm_wdata;
        dm_rdata <= dmem[dm_addr];
    end

    // CPU stub: one instruction per cycle.
    // op 0 LDA imm, 1 LDC imm, 2 A+=C, 3 C-=1, 4 BNZ imm, 5 STA imm, 6 HALT
    logic [7:0]  pc = '0;
    logic [15:0] ra = '0;
    logic [15:0] rc = '0;
    logic [15:0] instr;
    logic [3:0]  op;
    logic        exec;

    assign instr       = imem[pc];
    assign op          = instr[15:12];
    assign exec        = cpu_enable && !cpu_start;
    assign cpu_halt    = exec && (op == 4'd6);
    assign cpu_d_we    = exec && (op == 4'd5);
    assign cpu_d_addr  = instr[7:0];
    assign cpu_d_wdata = ra;
    assign cpu_i_addr  = pc;

    always @(posedge clk) begin
        if (cpu_start) begin
            pc <= '0;
            ra <= '0;
            rc <= '0;
        end else if (cpu_enable) begin
            pc <= pc + 8'd1;
            case (op)
                4'd0: ra <= {8'h00, instr[7:0]};
                4'd1: rc <= {8'h00, instr[7:0]};
                4'd2: ra <= ra + rc;
                4'd3: rc <= rc - 16'd1;
                4'd4: if (rc != 16'd0) pc <= instr[7:0];
                4'd6: pc <= pc;
                default: ;
            endcase
        end
    end

    // Reference model state and scoreboard
    typedef struct packed {
        logic [1:0]  st;
        logic [15:0] d;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_imem [256];
    logic [15:0] m_dmem [256];
    logic [15:0] last_rd = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int wr_cnt = 0;
    int rv_cnt = 0;
    int run_cnt = 0;
    int rv_cyc = 0;
    int acc_cyc = 0;
    int start_cyc = 0;
    logic        en_at_rv = 1'b0;
    logic [15:0] seen_d = '0;
    logic [1:0]  seen_st = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ISA-level interpretation of the program held in the model I-mem
    function automatic logic [1:0] run_model();
        logic [7:0]  p;
        logic [15:0] a;
        logic [15:0] c;
        logic [15:0] w;
        p = '0;
        a = '0;
        c = '0;
        for (int k = 0; k < TMO; k++) begin
            w = m_imem[p];
            if (w[15:12] == 4'd6) return S_HLT;
            case (w[15:12])
                4'd0: a = {8'h00, w[7:0]};
                4'd1: c = {8'h00, w[7:0]};
                4'd2: a = a + c;
                4'd3: c = c - 16'd1;
                4'd5: m_dmem[w[7:0]] = a;
                default: ;
            endcase
            if (w[15:12] == 4'd4 && c != 16'd0) p = w[7:0];
            else p = p + 8'd1;
        end
        return S_TMO;
    endfunction

    task automatic push_model(input logic [1:0] c, input logic [7:0] a,
                              input logic [15:0] d);
        exp_t e;
        e.st = S_OK;
        case (c)
            C_WRI: m_imem[a] = d;
            C_WRD: m_dmem[a] = d;
            C_RDD: last_rd = m_dmem[a];
            default: e.st = run_model();
        endcase
        e.d = last_rd;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && h_valid && h_ready) acc_cnt <= acc_cnt + 1;
    end

    // Monitor: pops the scoreboard on every response
    always @(negedge clk) begin
        exp_t e;
        if (dm_we && !cpu_enable) wr_cnt++;
        if (cpu_start) start_cyc = cyc;
        if (cpu_enable && !cpu_start) begin
            run_cnt++;
            chk("run_im_we", 32'(im_we), 32'd0);
            chk("run_im_addr", 32'(im_addr), 32'(cpu_i_addr));
        end
        if (r_valid) begin
            rv_cnt++;
            rv_cyc = cyc;
            en_at_rv = cpu_enable;
            seen_d = r_data;
            seen_st = r_status;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rvalid actual=1 required=0");
            end else begin
                e = sb.pop_front();
                chk("resp_status", 32'(r_status), 32'(e.st));
                chk("resp_data", 32'(r_data), 32'(e.d));
            end
        end
    end

    task automatic issue(input logic [1:0] c, input logic [7:0] a,
                         input logic [15:0] d, input bit keep);
        bit done;
        done = 1'b0;
        @(negedge clk);
        #1;
        h_valid = 1'b1;
        h_cmd   = c;
        h_addr  = a;
        h_wdata = d;
        for (int i = 0; i < 600 && !done; i++) begin
            if (h_ready) begin
                acc_cyc = cyc;
                push_model(c, a, d);
                done = 1'b1;
                @(posedge clk);
                #1;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        if (!keep) h_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) ok = 1'b1;
        end
        if (!ok) chk("resp_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic cmd(input logic [1:0] c, input logic [7:0] a,
                       input logic [15:0] d);
        issue(c, a, d, 1'b0);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int w0;
        for (int i = 0; i < 256; i++) begin
            m_imem[i] = '0;
            m_dmem[i] = '0;
        end

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_h_ready", 32'(h_ready), 32'd0);
        chk("rst_r_valid", 32'(r_valid), 32'd0);
        chk("rst_r_data", 32'(r_data), 32'd0);
        chk("rst_r_status", 32'(r_status), 32'd0);
        chk("rst_cpu_en", 32'(cpu_enable), 32'd0);
        chk("rst_cpu_start", 32'(cpu_start), 32'd0);
        chk("rst_we", 32'({im_we, dm_we}), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_h_ready", 32'(h_ready), 32'd1);

        // Sum-loop program: 4+3+2+1 stored to D-mem[2]
        cmd(C_WRI, 8'd0, 16'h0000);
        cmd(C_WRI, 8'd1, 16'h1004);
        cmd(C_WRI, 8'd2, 16'h2000);
        cmd(C_WRI, 8'd3, 16'h3000);
        cmd(C_WRI, 8'd4, 16'h4002);
        cmd(C_WRI, 8'd5, 16'h5002);
        cmd(C_WRI, 8'd6, 16'h6000);
        cmd(C_RUN, 8'd0, 16'h0000);
        chk("sum_status", 32'(seen_st), 32'(S_HLT));
        cmd(C_RDD, 8'd2, 16'h0000);
        chk("sum_value", 32'(seen_d), 32'd10);

        // Top address write/read with latency
        cmd(C_WRD, 8'hFF, 16'hA5A5);
        cmd(C_RDD, 8'hFF, 16'h0000);
        chk("ff_data", 32'(seen_d), 32'hA5A5);
        chk("ff_status", 32'(seen_st), 32'(S_OK));
        chk("rdd_latency", 32'(rv_cyc - acc_cyc), 32'd3);

        // Endless loop -> timeout after TMO run cycles
        cmd(C_WRI, 8'd0, 16'h1001);
        cmd(C_WRI, 8'd1, 16'h4001);
        run_cnt = 0;
        cmd(C_RUN, 8'd0, 16'h0000);
        chk("tmo_status", 32'(seen_st), 32'(S_TMO));
        chk("tmo_run_cycles", 32'(run_cnt), 32'(TMO));
        chk("tmo_resp_cycle", 32'(rv_cyc - start_cyc), 32'(TMO + 1));
        chk("tmo_en_at_resp", 32'(en_at_rv), 32'd0);
        chk("tmo_en_after", 32'(cpu_enable), 32'd0);

        // HALT on the final allowed cycle
        for (int i = 0; i < TMO - 1; i++) cmd(C_WRI, 8'(i), 16'h7000);
        cmd(C_WRI, 8'(TMO - 1), 16'h6000);
        cmd(C_RUN, 8'd0, 16'h0000);
        chk("tie_status", 32'(seen_st), 32'(S_HLT));

        // h_valid held high across three writes
        a0 = acc_cnt;
        w0 = wr_cnt;
        issue(C_WRD, 8'h10, 16'h1111, 1'b1);
        issue(C_WRD, 8'h11, 16'h2222, 1'b1);
        issue(C_WRD, 8'h12, 16'h3333, 1'b1);
        repeat (3) @(negedge clk);
        #1 h_valid = 1'b0;
        drain();
        chk("held_accepts", 32'(acc_cnt - a0), 32'd3);
        chk("held_writes", 32'(wr_cnt - w0), 32'd3);
        cmd(C_RDD, 8'h11, 16'h0000);

        // Reset mid-run aborts without a response
        cmd(C_WRI, 8'd0, 16'h1001);
        cmd(C_WRI, 8'd1, 16'h4001);
        issue(C_RUN, 8'd0, 16'h0000, 1'b0);
        repeat (10) @(negedge clk);
        #1;
        w0 = rv_cnt;
        rst = 1'b1;
        sb.delete();
        last_rd = '0;
        @(negedge clk);
        chk("abort_cpu_en", 32'(cpu_enable), 32'd0);
        chk("abort_h_ready", 32'(h_ready), 32'd0);
        chk("abort_r_data", 32'(r_data), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_h_ready_up", 32'(h_ready), 32'd1);
        repeat (TMO + 5) @(negedge clk);
        chk("abort_no_resp", 32'(rv_cnt - w0), 32'd0);

        // Randomised command mix against the model
        for (int n = 0; n < 80; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 3) begin
                cmd(C_WRD, 8'($urandom), 16'($urandom));
            end else if (r < 6) begin
                cmd(C_RDD, 8'($urandom), 16'h0000);
            end else if (r < 9) begin
                cmd(C_WRI, 8'($urandom_range(0, 15)),
                    {1'b0, 3'($urandom_range(0, 6)), 4'h0, 8'($urandom)});
            end else begin
                cmd(C_RUN, 8'd0, 16'h0000);
            end
        end
        for (int i = 0; i < 16; i++) cmd(C_RDD, 8'(i), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
